// File: rtl/asu_ddr5_freq_ratio_ctrl.sv
// Frequency-ratio sequencer for the DDR5 PHY write-path serializer: latches the
// DFI ratio, steps phase_sel through p0..p3 and runs the init_start/complete handshake.
module asu_ddr5_freq_ratio_ctrl #(
  parameter int pLOCK_CYCLES = 8,
  parameter int pCNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [2:0] dfi_freq_ratio_i,
  input  logic       dfi_init_start_i,
  input  logic       wr_busy_i,
  output logic       dfi_init_complete_o,
  output logic [2:0] ratio_o,
  output logic [1:0] phase_sel_o,
  output logic       ratio_enable_o,
  output logic       dfi_clk_en_o,
  output logic       ratio_err_o
);

  typedef enum logic [1:0] {IDLE, LOCK, RUN, DRAIN} state_t;

  localparam logic [pCNT_W-1:0] LOCK_LAST = pCNT_W'(pLOCK_CYCLES - 1);

  state_t            state_q;
  logic [pCNT_W-1:0] cnt_q;
  logic              start_q, pend_q;
  logic              cmp_q, ren_q, err_q;
  logic [2:0]        ratio_q;
  logic [1:0]        phase_q;

  logic       start_edge, ratio_ok;
  logic [2:0] ratio_lat_d;
  logic [1:0] last_ph, phase_d;

  assign start_edge  = dfi_init_start_i & ~start_q;
  assign ratio_ok    = (dfi_freq_ratio_i == 3'b000) || (dfi_freq_ratio_i == 3'b001) ||
                       (dfi_freq_ratio_i == 3'b010);
  assign ratio_lat_d = ratio_ok ? dfi_freq_ratio_i : 3'b000;

  always_comb begin
    last_ph = 2'd0;
    case (ratio_q)
      3'b001:  last_ph = 2'd1;
      3'b010:  last_ph = 2'd3;
      default: last_ph = 2'd0;
    endcase
  end

  assign phase_d = (phase_q == last_ph) ? 2'd0 : phase_q + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      pend_q  <= 1'b0;
      cmp_q   <= 1'b0;
      ren_q   <= 1'b0;
      err_q   <= 1'b0;
      ratio_q <= 3'b000;
      phase_q <= 2'd0;
    end else begin
      start_q <= dfi_init_start_i;
      if (!enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        cmp_q   <= 1'b0;
        ren_q   <= 1'b0;
        ratio_q <= 3'b000;
        phase_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= LOCK;
            ratio_q <= ratio_lat_d;
            cnt_q   <= '0;
            if (!ratio_ok) err_q <= 1'b1;
          end
          LOCK: begin
            if (cnt_q == LOCK_LAST) begin
              state_q <= RUN;
              cmp_q   <= 1'b1;
              ren_q   <= 1'b1;
              phase_q <= 2'd0;
              // a start edge coinciding with lock completion must not be lost
              pend_q  <= start_edge;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RUN: begin
            phase_q <= phase_d;
            pend_q  <= 1'b0;
            if (start_edge || pend_q) begin
              state_q <= DRAIN;
              cmp_q   <= 1'b0;
            end
          end
          DRAIN: begin
            // only leave on a DFI-cycle boundary with no write data in flight
            if (phase_q == last_ph && !wr_busy_i) begin
              state_q <= LOCK;
              ratio_q <= ratio_lat_d;
              phase_q <= 2'd0;
              ren_q   <= 1'b0;
              cnt_q   <= '0;
              if (!ratio_ok) err_q <= 1'b1;
            end else begin
              phase_q <= phase_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dfi_init_complete_o = cmp_q;
  assign ratio_o             = ratio_q;
  assign phase_sel_o         = phase_q;
  assign ratio_enable_o      = ren_q;
  assign ratio_err_o         = err_q;
  assign dfi_clk_en_o        = ((state_q == RUN) || (state_q == DRAIN)) && (phase_q == 2'd0);

endmodule

// File: tb/tb_asu_ddr5_freq_ratio_ctrl.sv
// Bench for asu_ddr5_freq_ratio_ctrl: directed scenarios plus random traffic, each
// cycle compared against a countdown/flag model of the ratio handshake.
module tb_asu_ddr5_freq_ratio_ctrl;

  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst, en, start, busy;
  logic [2:0] ratio_in;
  logic       cmp, ren, clk_en, err;
  logic [2:0] ratio_o;
  logic [1:0] phase;
  logic [9:0] dut_vec;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  asu_ddr5_freq_ratio_ctrl #(.pLOCK_CYCLES(L), .pCNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .dfi_freq_ratio_i(ratio_in),
    .dfi_init_start_i(start), .wr_busy_i(busy), .dfi_init_complete_o(cmp),
    .ratio_o(ratio_o), .phase_sel_o(phase), .ratio_enable_o(ren),
    .dfi_clk_en_o(clk_en), .ratio_err_o(err)
  );

  assign dut_vec = {cmp, ratio_o, phase, ren, clk_en, err};

  // Model: active = out of IDLE, lock_left > 0 = still locking, draining flag
  bit m_active, m_drain, m_pend, m_prev, m_cmp, m_ren, m_err;
  int m_left, m_ratio, m_phase;

  function automatic int nph(int r);
    return (r == 1) ? 2 : (r == 2) ? 4 : 1;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic ce;
    ce = m_active && m_left == 0 && m_phase == 0;
    return {m_cmp, 3'(m_ratio), 2'(m_phase), m_ren, ce, m_err};
  endfunction

  task automatic model_latch();
    if (ratio_in <= 3'd2) m_ratio = int'(ratio_in);
    else begin m_ratio = 0; m_err = 1; end
    m_left = L;
  endtask

  task automatic tick();
    bit edge_s;
    @(posedge clk);
    edge_s = start && !m_prev;
    if (rst) begin
      m_active = 0; m_drain = 0; m_pend = 0; m_prev = 0; m_cmp = 0; m_ren = 0;
      m_err = 0; m_left = 0; m_ratio = 0; m_phase = 0;
    end else begin
      if (!en) begin
        m_active = 0; m_drain = 0; m_pend = 0; m_left = 0; m_cmp = 0; m_ren = 0;
        m_phase = 0; m_ratio = 0;
      end else if (!m_active) begin
        m_active = 1; model_latch();
      end else if (m_left > 0) begin
        if (m_left == 1) begin
          m_left = 0; m_cmp = 1; m_ren = 1; m_phase = 0; m_pend = edge_s;
        end else m_left--;
      end else if (!m_drain) begin
        m_phase = (m_phase + 1) % nph(m_ratio);
        if (edge_s || m_pend) begin m_drain = 1; m_cmp = 0; end
        m_pend = 0;
      end else begin
        if (m_phase == nph(m_ratio) - 1 && !busy) begin
          m_drain = 0; model_latch(); m_phase = 0; m_ren = 0;
        end else m_phase = (m_phase + 1) % nph(m_ratio);
      end
      m_prev = start;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; start = 0; busy = 0; ratio_in = 3'b010;
    tick(); tick();
    n_chk++;
    if (dut_vec !== 10'h0) begin n_err++; $display("FAIL reset: got %h want %h", dut_vec, 10'h0); end
    rst = 0; tick();
    n_chk++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_lock_latency();
    int lat = 0; int ce_cnt = 0;
    en = 1; ratio_in = 3'b010;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL lock_seq: got %h want %h", dut_vec, exp_vec()); end
      if (cmp) lat = i;
    end
    n_chk++;
    if (lat != L + 1) begin n_err++; $display("FAIL lock_latency: got %0d want %0d", lat, L + 1); end
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (phase !== 2'(i % 4)) begin n_err++; $display("FAIL phase_1to4: got %0d want %0d", phase, i % 4); end
      if (clk_en) ce_cnt++;
      tick();
    end
    n_chk++;
    if (ce_cnt != 3) begin n_err++; $display("FAIL clk_en_1to4: got %0d want 3", ce_cnt); end
  endtask

  task automatic test_drain();
    int lat = 0;
    for (int i = 0; i < 8 && phase !== 2'd1; i++) tick();
    start = 1; ratio_in = 3'b001; tick();
    n_chk++;
    if (cmp !== 1'b0 || phase !== 2'd2) begin
      n_err++; $display("FAIL drain_enter: got cmp=%b ph=%0d want cmp=0 ph=2", cmp, phase);
    end
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL drain_seq: got %h want %h", dut_vec, exp_vec()); end
      if (cmp) lat = i;
    end
    n_chk++;
    if (lat != L + 2) begin n_err++; $display("FAIL drain_relock: got %0d want %0d", lat, L + 2); end
    start = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (phase !== 2'(i % 2)) begin n_err++; $display("FAIL phase_1to2: got %0d want %0d", phase, i % 2); end
      tick();
    end
  endtask

  task automatic test_drain_busy();
    int lat = 0;
    ratio_in = 3'b010; start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && !cmp; i++) tick();
    for (int i = 0; i < 8 && phase !== 2'd1; i++) tick();
    start = 1; busy = 1; tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL busy_hold: got %h want %h", dut_vec, exp_vec()); end
    end
    n_chk++;
    if (ren !== 1'b1 || phase !== 2'd0) begin
      n_err++; $display("FAIL busy_stay: got ren=%b ph=%0d want ren=1 ph=0", ren, phase);
    end
    busy = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (!ren) lat = i;
    end
    n_chk++;
    if (lat != 4) begin n_err++; $display("FAIL busy_exit: got %0d want 4", lat); end
    start = 0;
  endtask

  task automatic test_ratio11_illegal();
    ratio_in = 3'b000;
    for (int i = 0; i < 40 && !cmp; i++) tick();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && !cmp; i++) tick();
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (phase !== 2'd0 || clk_en !== 1'b1) begin
        n_err++; $display("FAIL ratio_1to1: got ph=%0d ce=%b want ph=0 ce=1", phase, clk_en);
      end
      tick();
    end
    ratio_in = 3'b101; start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && !cmp; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL illegal_seq: got %h want %h", dut_vec, exp_vec()); end
    end
    n_chk++;
    if (ratio_o !== 3'b000 || err !== 1'b1 || cmp !== 1'b1) begin
      n_err++; $display("FAIL illegal_ratio: got r=%b err=%b cmp=%b want r=000 err=1 cmp=1", ratio_o, err, cmp);
    end
  endtask

  task automatic test_enable_drop();
    int lat = 0;
    ratio_in = 3'b010; start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && !cmp; i++) tick();
    for (int i = 0; i < 8 && phase !== 2'd1; i++) tick();
    start = 1; tick();
    n_chk++;
    if (phase !== 2'd2 || cmp !== 1'b0) begin n_err++; $display("FAIL en_drain_pre: got ph=%0d cmp=%b want 2/0", phase, cmp); end
    en = 0; tick(); start = 0;
    n_chk++;
    if (dut_vec !== 10'h001) begin n_err++; $display("FAIL en_drop: got %h want %h", dut_vec, 10'h001); end
    en = 1;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL en_relock_seq: got %h want %h", dut_vec, exp_vec()); end
      if (cmp) lat = i;
    end
    n_chk++;
    if (lat != L + 1) begin n_err++; $display("FAIL en_relock: got %0d want %0d", lat, L + 1); end
  endtask

  task automatic test_reset_mid();
    tick();
    rst = 1; start = 1; tick(); rst = 0;
    n_chk++;
    if (dut_vec !== 10'h0) begin n_err++; $display("FAIL reset_mid: got %h want %h", dut_vec, 10'h0); end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_mid_seq: got %h want %h", dut_vec, exp_vec()); end
    end
    n_chk++;
    if (cmp !== 1'b1) begin n_err++; $display("FAIL start_held: got cmp=%b want 1", cmp); end
    start = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 39) != 0);
      start    = ($urandom_range(0, 5) == 0) ? ~start : start;
      busy     = ($urandom_range(0, 2) == 0);
      ratio_in = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      tick();
      n_chk++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_drain();
    test_drain_busy();
    test_ratio11_illegal();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
